// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   DATA_SIZE_DEFAULT : default width of one FIFO word in bits
//   state_t           : arbiter state encoding (IDLE = 0, BUSY = 1)
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_SIZE_DEFAULT = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority encoder. The scan starts at index rr_ptr
// and wraps modulo NUM_REQ; the first set request bit wins.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index with highest priority this cycle
//   pick   out NUM_REQ  one-hot winner (all zero when nothing requests)
//   valid  out 1        at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    // Walk the requesters in rotated order; once valid is set the
    // remaining candidates are masked so pick stays one-hot.
    always_comb begin
        logic [PTR_W-1:0] idx;
        pick  = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares the single write port of the UART TX FIFO between NUM_REQ byte
// producers. Round-robin grant that is held for a whole frame, with writes
// back-pressured by the FIFO full flag.
// Ports:
//   clk         in  1                  system clock, rising edge
//   reset       in  1                  synchronous active-high reset
//   req         in  NUM_REQ            requester i wants the FIFO
//   wr_in       in  NUM_REQ            requester i presents a valid byte
//   last_in     in  NUM_REQ            presented byte ends the frame
//   w_data_in   in  NUM_REQ*DATA_SIZE  lane i at [i*DATA_SIZE +: DATA_SIZE]
//   gnt         out NUM_REQ            registered one-hot grant
//   ack         out NUM_REQ            byte of requester i accepted (comb.)
//   fifo_full   in  1                  FIFO full flag
//   fifo_wr     out 1                  FIFO write strobe (comb.)
//   fifo_w_data out DATA_SIZE          FIFO write data (granted lane)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             wr_in,
    input  logic [NUM_REQ-1:0]             last_in,
    input  logic [NUM_REQ*DATA_SIZE-1:0]   w_data_in,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             ack,
    input  logic                           fifo_full,
    output logic                           fifo_wr,
    output logic [DATA_SIZE-1:0]           fifo_w_data
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t             state, state_next;
    logic [NUM_REQ-1:0] gnt_next;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_next, burst_inc;
    logic [NUM_REQ-1:0] pick;
    logic               pick_valid;
    logic [PTR_W-1:0]   gnt_idx;
    logic               release_now;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick),
        .valid  (pick_valid)
    );

    // Binary index of the granted lane, used to steer the lane mux.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // Write path. A byte is only taken from the granted lane while busy and
    // the FIFO has room; reset blocks writes combinationally so a frame being
    // cut off cannot push one more byte in the reset cycle.
    always_comb begin
        fifo_wr     = (state == BUSY) && !reset && wr_in[gnt_idx] && !fifo_full;
        ack         = fifo_wr ? gnt : '0;
        fifo_w_data = w_data_in[gnt_idx*DATA_SIZE +: DATA_SIZE];
        burst_inc   = burst_cnt + CNT_W'(1);
        // Release on end of frame, on hitting the burst limit, or when the
        // owner withdraws without handing over a byte this cycle.
        release_now = (state == BUSY) &&
                      ((fifo_wr && (last_in[gnt_idx] || burst_inc == CNT_W'(MAX_BURST))) ||
                       (!fifo_wr && !req[gnt_idx]));
    end

    // Next-state logic. A grant always passes through IDLE, which keeps the
    // grant one-hot and gives the rotation pointer time to settle.
    always_comb begin
        state_next     = state;
        gnt_next       = gnt;
        rr_ptr_next    = rr_ptr;
        burst_cnt_next = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next     = BUSY;
                    gnt_next       = pick;
                    burst_cnt_next = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    state_next  = IDLE;
                    gnt_next    = '0;
                    rr_ptr_next = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
                end else if (fifo_wr) begin
                    burst_cnt_next = burst_inc;
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_next;
            gnt       <= gnt_next;
            rr_ptr    <= rr_ptr_next;
            burst_cnt <= burst_cnt_next;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Self-checking bench for uart_tx_arbiter: directed scenarios with literal
// expectations, then randomized producers checked every cycle against a
// behavioural model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  wr_in = '0;
    logic [N-1:0]  last_in = '0;
    logic [N*DW-1:0] w_data_in = '0;
    logic          fifo_full = 1'b0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  ack;
    logic          fifo_wr;
    logic [DW-1:0] fifo_w_data;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state: owner index (-1 when nobody holds the FIFO),
    // next priority index, bytes accepted in the current grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [DW-1:0] wlog[$];
    logic [N-1:0]  acked = '0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DATA_SIZE(DW), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wr_in       (wr_in),
        .last_in     (last_in),
        .w_data_in   (w_data_in),
        .gnt         (gnt),
        .ack         (ack),
        .fifo_full   (fifo_full),
        .fifo_wr     (fifo_wr),
        .fifo_w_data (fifo_w_data)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare on the falling edge: inputs are stable and equal to what the
    // next rising edge will sample, so the model advances here as well.
    always @(negedge clk) begin
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_ack;
        logic          e_wr;
        logic [DW-1:0] e_data;
        bit            rel;
        bit            found;
        int            k;
        e_gnt  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        e_wr   = 1'b0;
        e_ack  = '0;
        e_data = '0;
        rel    = 1'b0;
        found  = 1'b0;
        k      = 0;
        if (!reset && m_owner >= 0) begin
            e_wr   = wr_in[m_owner] && !fifo_full;
            e_data = w_data_in[m_owner*DW +: DW];
            if (e_wr) e_ack = e_gnt;
        end
        checkOutput("model_gnt", gnt, e_gnt);
        checkOutput("model_fifo_wr", fifo_wr, e_wr);
        checkOutput("model_ack", ack, e_ack);
        if (e_wr) checkOutput("model_data", fifo_w_data, e_data);
        acked = ack;
        if (fifo_wr) wlog.push_back(fifo_w_data);

        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            for (int s = 0; s < N; s++) begin
                k = (m_ptr + s) % N;
                if (!found && req[k]) begin
                    found   = 1'b1;
                    m_owner = k;
                    m_cnt   = 0;
                end
            end
        end else begin
            if (e_wr) m_cnt++;
            rel = (e_wr && (last_in[m_owner] || m_cnt == MB)) || (!e_wr && !req[m_owner]);
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req       = '0;
        wr_in     = '0;
        last_in   = '0;
        w_data_in = '0;
        fifo_full = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        clearInputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Randomized producers: each holds its byte until acknowledged, raises
    // and drops req at random, and the FIFO fills up at random.
    task automatic applyStimulus(input int cycles);
        int r;
        for (int c = 0; c < cycles; c++) begin
            reset     = ($urandom_range(0, 199) == 0);
            fifo_full = ($urandom_range(0, 9) < 3);
            for (int i = 0; i < N; i++) begin
                if (acked[i]) begin
                    wr_in[i]   = 1'b0;
                    last_in[i] = 1'b0;
                end
                if (!req[i]) begin
                    if ($urandom_range(0, 4) == 0) req[i] = 1'b1;
                end else if (!wr_in[i]) begin
                    r = $urandom_range(0, 9);
                    if (r < 5) begin
                        wr_in[i]             = 1'b1;
                        w_data_in[i*DW +: DW] = DW'($urandom);
                        last_in[i]           = ($urandom_range(0, 3) == 0);
                    end else if (r == 5) begin
                        req[i] = 1'b0;
                    end
                end
            end
            tick();
        end
    endtask

    initial begin
        logic [DW-1:0] t1b[3];
        logic [N-1:0]  t2exp[9];
        int            base;
        t1b   = '{8'h6C, 8'hAF, 8'h64};
        t2exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                  4'b0000, 4'b1000, 4'b0000, 4'b0001};

        doReset();
        checkOutput("reset_gnt", gnt, 0);
        checkOutput("reset_fifo_wr", fifo_wr, 0);

        // Single three-byte frame on lane 0.
        req = 4'b0001;
        tick();
        checkOutput("t1_gnt_latency", gnt, 4'b0001);
        base = wlog.size();
        for (int j = 0; j < 3; j++) begin
            wr_in[0]          = 1'b1;
            w_data_in[7:0]    = t1b[j];
            last_in[0]        = (j == 2);
            tick();
        end
        clearInputs();
        checkOutput("t1_release", gnt, 0);
        checkOutput("t1_count", wlog.size() - base, 3);
        for (int j = 0; j < 3; j++) checkOutput("t1_data", wlog[base + j], t1b[j]);

        // All four requesting, one-byte frames: strict rotation with a gap.
        doReset();
        req       = 4'b1111;
        wr_in     = 4'b1111;
        last_in   = 4'b1111;
        w_data_in = {8'd3, 8'd2, 8'd1, 8'd0};
        for (int j = 0; j < 9; j++) begin
            tick();
            checkOutput("t2_order", gnt, t2exp[j]);
        end

        // Back-pressure: byte held through four full cycles, written once.
        doReset();
        req = 4'b0001;
        tick();
        base           = wlog.size();
        fifo_full      = 1'b1;
        wr_in          = 4'b0001;
        last_in        = 4'b0001;
        w_data_in[7:0] = 8'h81;
        for (int j = 0; j < 4; j++) begin
            #1;
            checkOutput("t3_full_wr", fifo_wr, 0);
            checkOutput("t3_full_ack", ack, 0);
            tick();
        end
        fifo_full = 1'b0;
        #1;
        checkOutput("t3_wr", fifo_wr, 1);
        checkOutput("t3_data", fifo_w_data, 8'h81);
        tick();
        clearInputs();
        checkOutput("t3_release", gnt, 0);
        checkOutput("t3_once", wlog.size() - base, 1);

        // Burst limit: a one-byte frame on lane 1 moves priority to lane 2,
        // lane 2 then streams without last while lane 1 waits.
        doReset();
        req             = 4'b0010;
        wr_in           = 4'b0010;
        last_in         = 4'b0010;
        w_data_in[15:8] = 8'h11;
        tick();
        checkOutput("t4_gnt1", gnt, 4'b0010);
        tick();
        checkOutput("t4_idle", gnt, 0);
        req     = 4'b0110;
        wr_in   = 4'b0100;
        last_in = 4'b0000;
        tick();
        checkOutput("t4_gnt2", gnt, 4'b0100);
        base = wlog.size();
        for (int j = 0; j < MB; j++) begin
            w_data_in[23:16] = DW'(8'hA0 + j);
            tick();
        end
        checkOutput("t4_burst_release", gnt, 0);
        checkOutput("t4_burst_count", wlog.size() - base, MB);
        tick();
        checkOutput("t4_next_grant", gnt, 4'b0010);
        clearInputs();
        tick();
        tick();

        // Owner withdraws mid-frame without last.
        doReset();
        req = 4'b0010;
        tick();
        wr_in           = 4'b0010;
        w_data_in[15:8] = 8'h55;
        tick();
        w_data_in[15:8] = 8'h56;
        tick();
        req   = '0;
        wr_in = '0;
        #1;
        checkOutput("t5_no_wr", fifo_wr, 0);
        tick();
        checkOutput("t5_release", gnt, 0);
        req = 4'b1111;
        tick();
        checkOutput("t5_rr_ptr", gnt, 4'b0100);

        // Reset in the middle of lane 2's frame.
        wr_in = 4'b0100;
        reset = 1'b1;
        #1;
        checkOutput("t6_reset_wr", fifo_wr, 0);
        checkOutput("t6_reset_ack", ack, 0);
        tick();
        checkOutput("t6_gnt_drop", gnt, 0);
        reset = 1'b0;
        req   = 4'b0100;
        wr_in = '0;
        tick();
        checkOutput("t6_regrant", gnt, 4'b0100);
        clearInputs();
        tick();
        tick();

        applyStimulus(4000);

        reset = 1'b0;
        clearInputs();
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
